anubis_sigma_iter: RTL and testbench



---
 rtl/anubis_pkg.sv | 12 +
 rtl/sigma_lane.sv | 12 +
 rtl/anubis_sigma_iter.sv | 103 ++++++++++
 tb/tb_anubis_sigma_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_pkg.sv
// Shared constants and types for the Anubis round datapath.
package anubis_pkg;

    localparam int ANUBIS_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/sigma_lane.sv
// One lane of the sigma key addition: a plain XOR of state and round-key bits.
module sigma_lane #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/anubis_sigma_iter.sv
// Lane-serial sigma key addition: XORs a latched block with its round key
// LANE_W bits per cycle and hands the result out through a valid/ready port.
module anubis_sigma_iter
    import anubis_pkg::*;
#(
    parameter int BLOCK_W = ANUBIS_BLOCK_W,
    parameter int LANE_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy,
    output logic [CNT_W-1:0]   block_cnt
);

    localparam int N          = BLOCK_W / LANE_W;
    localparam int LANE_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(N - 1);

    if (BLOCK_W % LANE_W != 0) begin : g_bad_lane
        $error("anubis_sigma_iter: LANE_W must divide BLOCK_W");
    end

    state_t                state_q, state_d;
    logic [BLOCK_W-1:0]    data_q, key_q;
    logic [LANE_CNT_W-1:0] lane_cnt;
    logic [LANE_W-1:0]     lane_x;
    logic [31:0]           lane_base;
    logic                  load, out_fire;

    assign lane_base = 32'(lane_cnt) * 32'(LANE_W);

    sigma_lane #(.W(LANE_W)) u_lane (
        .a (data_q[lane_base +: LANE_W]),
        .b (key_q[lane_base +: LANE_W]),
        .y (lane_x)
    );

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rst_n gate keeps in_ready low for the whole reset pulse.
                in_ready = rst_n;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (lane_cnt == LAST_LANE) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load     = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            key_q     <= '0;
            lane_cnt  <= '0;
            out_data  <= '0;
            block_cnt <= '0;
        end else begin
            if (load) begin
                data_q   <= in_data;
                key_q    <= in_key;
                lane_cnt <= '0;
            end else if (busy) begin
                out_data[lane_base +: LANE_W] <= lane_x;
                lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
            end
            if (out_fire) block_cnt <= block_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_anubis_sigma_iter.sv
// Directed bench for anubis_sigma_iter: default, full-width-lane and narrow-counter builds.
module tb_anubis_sigma_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build: 4 lanes of 32 bits, 16-bit counter.
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;
    logic [15:0]  block_cnt;

    // Full-width lane build and 4-bit counter build share rst_aux.
    logic         rst_aux;
    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [127:0] w_in_data, w_in_key, w_out_data;
    logic [15:0]  w_block_cnt;
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [127:0] c_in_data, c_in_key, c_out_data;
    logic [3:0]   c_block_cnt;

    anubis_sigma_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .block_cnt(block_cnt)
    );

    anubis_sigma_iter #(.LANE_W(128)) dut_w (
        .clk(clk), .rst_n(rst_aux), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_key(w_in_key), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy), .block_cnt(w_block_cnt)
    );

    anubis_sigma_iter #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_aux), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_key(c_in_key), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy), .block_cnt(c_block_cnt)
    );

    int exp_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair on the default build and return once the input handshake edge has passed.
    task automatic send(input logic [127:0] d, input logic [127:0] k);
        int n = 0;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        #0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_key   = ~k;
    endtask

    // Edges from the input handshake until out_valid, and how many of those cycles had busy high.
    task automatic wait_out(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        check("cnt_after_take", 128'(block_cnt), 128'(exp_cnt));
        check("valid_after_take", 128'(out_valid), 128'(0));
    endtask

    initial begin
        int lat, bn, rises, hs, cyc;
        logic [127:0] held;

        rst_n = 1'b0; rst_aux = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_data = '0; w_in_key = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_key = '0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_block_cnt", 128'(block_cnt), 128'(0));
        tick(); tick();
        rst_n = 1'b1; rst_aux = 1'b1;
        #1;
        check("idle_in_ready", 128'(in_ready), 128'(1));

        // Basic block: latency 4, busy for 4 cycles, input changes after handshake ignored.
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        wait_out(lat, bn);
        check("basic_latency", 128'(lat), 128'(4));
        check("basic_busy_cycles", 128'(bn), 128'(4));
        check("basic_busy_done", 128'(busy), 128'(0));
        check("basic_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        consume();
        check("basic_back_idle", 128'(in_ready), 128'(1));

        // Truth table: C ^ A = 6 in every nibble.
        send({32{4'hC}}, {32{4'hA}});
        wait_out(lat, bn);
        check("tt_data", out_data, {32{4'h6}});
        consume();

        // Back-pressure for 10 cycles, then simultaneous output/input handshake.
        send(128'h0123456789abcdeffedcba9876543210, 128'hffffffff00000000ffffffff00000000);
        wait_out(lat, bn);
        check("bp_latency", 128'(lat), 128'(4));
        held = 128'hfedcba9889abcdef0123456776543210;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        in_data   = {4{32'hdeadbeef}};
        in_key    = {4{32'hffffffff}};
        out_ready = 1'b1;
        #1;
        check("bp_ready_follows", 128'(in_ready), 128'(1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        exp_cnt++;
        check("bp_cnt", 128'(block_cnt), 128'(exp_cnt));
        check("bp_b2b_busy", 128'(busy), 128'(1));
        wait_out(lat, bn);
        check("bp_b2b_latency", 128'(lat), 128'(4));
        check("bp_b2b_data", out_data, {4{32'h21524110}});
        consume();

        // Reset after lane 1 discards the block and clears everything immediately.
        send({16{8'h11}}, {16{8'h22}});
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_out_data", out_data, 128'(0));
        check("mid_rst_cnt", 128'(block_cnt), 128'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        send({16{8'h5a}}, {16{8'h0f}});
        wait_out(lat, bn);
        check("post_rst_latency", 128'(lat), 128'(4));
        check("post_rst_data", out_data, {16{8'h55}});
        consume();

        // Full-width lane: one-edge latency and one block every two cycles.
        w_in_data  = {8{16'h1234}};
        w_in_key   = {8{16'hf0f0}};
        w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        check("w_busy", 128'(w_busy), 128'(1));
        tick();
        check("w_latency_valid", 128'(w_out_valid), 128'(1));
        check("w_data", w_out_data, {8{16'he2c4}});
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        check("w_cnt_first", 128'(w_block_cnt), 128'(1));
        w_in_valid  = 1'b1;
        w_out_ready = 1'b1;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_out_valid) rises++;
        end
        check("w_results_in_20", 128'(rises), 128'(10));
        check("w_cnt_in_20", 128'(w_block_cnt), 128'(10));
        w_in_valid = 1'b0;
        tick();
        w_out_ready = 1'b0;
        check("w_cnt_final", 128'(w_block_cnt), 128'(11));

        // 4-bit counter: 17 completed blocks wrap to 1.
        c_in_data   = {16{8'h3c}};
        c_in_key    = {16{8'hff}};
        c_in_valid  = 1'b1;
        c_out_ready = 1'b1;
        hs  = 0;
        cyc = 0;
        while (hs < 17 && cyc < 500) begin
            if (c_out_valid) begin
                hs++;
                if (hs == 1) check("c_data", c_out_data, {16{8'hc3}});
            end
            tick();
            cyc++;
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        check("c_handshakes", 128'(hs), 128'(17));
        check("c_wrap_cnt", 128'(c_block_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
